// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e       : FSM state encodings (2-bit, registered in the top)
//   REG_ZERO      : architectural $zero register index, never a real hazard source
//   load_use_hit  : load-use dependency compare between the EX load and the ID sources
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is excluded because writes to it are discarded, so no data is produced.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high, clears q
//   inc : count this cycle
//   q   : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Inputs : clk, rst (sync, active-high), ID sources (id_rs, id_rt, id_uses_rt),
//          id_redirect, EX load info (ex_mem_read, ex_rt), MEM handshake
//          (mem_req, mem_ready).
// Outputs: pipeline register controls (pc_write, if_id_write, if_id_flush,
//          id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble), sticky mem_err,
//          saturating counters load_stall_cnt, mem_stall_cnt, flush_cnt.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RUN      | normal flow; load-use bubbles and redirect flushes allowed
// ST_MEM_WAIT | data memory access outstanding; pipeline frozen, timer runs
// ST_ERROR    | memory timed out; pipeline frozen until rst
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_redirect,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait timer counts down the MEM_WAIT cycles still tolerated. It is loaded
  // on entry so that the cycle in which it reads zero is the TIMEOUT-th MEM_WAIT
  // cycle; still waiting then means a timeout.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;

  logic mem_wait;
  logic load_use;
  logic load_inc, mem_inc, flush_inc;

  assign mem_wait = mem_req && !mem_ready;
  assign load_use = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_MEM_WAIT;
          tmo_d   = TMO_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (tmo_q == '0) begin
          state_d   = ST_ERROR;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase
  end

  // Outputs follow the current inputs in the same cycle so the pipeline
  // registers see the hold/bubble on the edge that would otherwise advance them.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    load_inc      = 1'b0;
    mem_inc       = 1'b0;
    flush_inc     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_wait) begin
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            mem_inc       = 1'b1;
          end else if ((state_q == ST_RUN) && load_use) begin
            // Redirect is dropped here: its compare used stale operands and
            // is seen again next cycle once the load has written back.
            id_ex_bubble = 1'b1;
            load_inc     = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if ((state_q == ST_RUN) && id_redirect) begin
              if_id_flush = 1'b1;
              flush_inc   = 1'b1;
            end
          end
        end
        default: begin
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .inc (load_inc),
    .q   (load_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_inc),
    .q   (mem_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

endmodule
